// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA timing, sync and 4-bit DAC output stage (optional VGA_FRAME_TICK_EN)
//
// Free-running pixel/line counters decode the visible area and the sync
// windows; a single output register stage aligns HSYNC, VSYNC and the
// blanked colour pins so they all describe the same pixel.
// Define VGA_FRAME_TICK_EN to add the FrameTick/FrameCount outputs.

module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       CLK25M,
  input  logic       Reset,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] Hcount,
  output logic [8:0] Vcount,
  output logic       VideoOn,
  output logic [3:0] vgaRed,
  output logic [3:0] vgaGreen,
  output logic [3:0] vgaBlue,
  output logic       HSYNC,
  output logic       VSYNC
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic        FrameTick,
  output logic [15:0] FrameCount
`endif
);

  // Frame geometry; both totals must stay within the 10-bit counters.
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       frame_end;
  logic       video_on;
  logic       hsync_n;
  logic       vsync_n;
  logic [3:0] red_px;
  logic [3:0] green_px;
  logic [3:0] blue_px;

  // Only the upper nibble of each colour reaches the 4-bit DAC.
  logic unused_colour_low;
  assign unused_colour_low = ^{Red[3:0], Green[3:0], Blue[3:0]};

  // Line and frame boundary decode from the current counters.
  always_comb begin
    h_wrap    = (h_cnt == H_LAST);
    frame_end = h_wrap && (v_cnt == V_LAST);
  end

  // Pixel counter runs every clock and wraps at the end of the line.
  always_ff @(posedge CLK25M or posedge Reset) begin
    if (Reset) begin
      h_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Line counter advances only when the pixel counter wraps; the last line
  // of the frame wraps together with the last pixel.
  always_ff @(posedge CLK25M or posedge Reset) begin
    if (Reset) begin
      v_cnt <= '0;
    end else if (h_wrap) begin
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end
  end

  // Visible-area and active-low sync window decode for the current pixel.
  always_comb begin
    video_on = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    hsync_n  = !((h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST));
    vsync_n  = !((v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST));
    red_px   = video_on ? Red[7:4]   : 4'h0;
    green_px = video_on ? Green[7:4] : 4'h0;
    blue_px  = video_on ? Blue[7:4]  : 4'h0;
  end

  // Coordinates go straight to the colour logic; lines 512+ alias in the
  // truncated Vcount but VideoOn is low there so nothing is drawn.
  assign Hcount  = h_cnt;
  assign Vcount  = v_cnt[8:0];
  assign VideoOn = video_on;

  // Output register: sync and blanked colour pins move together, one cycle
  // behind the counters.
  always_ff @(posedge CLK25M or posedge Reset) begin
    if (Reset) begin
      HSYNC    <= 1'b1;
      VSYNC    <= 1'b1;
      vgaRed   <= 4'h0;
      vgaGreen <= 4'h0;
      vgaBlue  <= 4'h0;
    end else begin
      HSYNC    <= hsync_n;
      VSYNC    <= vsync_n;
      vgaRed   <= red_px;
      vgaGreen <= green_px;
      vgaBlue  <= blue_px;
    end
  end

`ifdef VGA_FRAME_TICK_EN
  logic        frame_tick;
  logic [15:0] frame_cnt;

  // Frame pulse lands with the pins showing pixel 0,0; the frame count
  // steps on the same edge so it reads the new value while the pulse is high.
  always_ff @(posedge CLK25M or posedge Reset) begin
    if (Reset) begin
      frame_tick <= 1'b0;
      frame_cnt  <= 16'h0000;
    end else begin
      frame_tick <= frame_end;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'h0001;
      end
    end
  end

  assign FrameTick  = frame_tick;
  assign FrameCount = frame_cnt;
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen
module tb_vga_sync_gen;

  logic       CLK25M;
  logic       Reset;
  logic [7:0] Red;
  logic [7:0] Green;
  logic [7:0] Blue;
  logic [9:0] Hcount;
  logic [8:0] Vcount;
  logic       VideoOn;
  logic [3:0] vgaRed;
  logic [3:0] vgaGreen;
  logic [3:0] vgaBlue;
  logic       HSYNC;
  logic       VSYNC;
`ifdef VGA_FRAME_TICK_EN
  logic        FrameTick;
  logic [15:0] FrameCount;
`endif

  vga_sync_gen dut (
    .CLK25M   (CLK25M),
    .Reset    (Reset),
    .Red      (Red),
    .Green    (Green),
    .Blue     (Blue),
    .Hcount   (Hcount),
    .Vcount   (Vcount),
    .VideoOn  (VideoOn),
    .vgaRed   (vgaRed),
    .vgaGreen (vgaGreen),
    .vgaBlue  (vgaBlue),
    .HSYNC    (HSYNC),
    .VSYNC    (VSYNC)
`ifdef VGA_FRAME_TICK_EN
    ,
    .FrameTick  (FrameTick),
    .FrameCount (FrameCount)
`endif
  );

  initial CLK25M = 1'b0;
  always #20 CLK25M = ~CLK25M;

  typedef struct {
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        ft;
    logic [15:0] fc;
  } pin_t;

  pin_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [9:0]  mh;
  logic [9:0]  mv;
  logic [15:0] mfc;
  int          ft_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One pixel: check coordinates now, predict next pins, clock, compare pins.
  task automatic tick(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pin_t e;
    pin_t got;
    logic von;
    Red = r;
    Green = g;
    Blue = b;
    von = (mh < 10'd640) && (mv < 10'd480);
    check("hcount", 32'(Hcount), 32'(mh));
    check("vcount", 32'(Vcount), 32'(mv[8:0]));
    check("videoon", 32'(VideoOn), 32'(von));
    e.hs = !(mh >= 10'd656 && mh <= 10'd751);
    e.vs = !(mv >= 10'd490 && mv <= 10'd491);
    e.r  = von ? r[7:4] : 4'h0;
    e.g  = von ? g[7:4] : 4'h0;
    e.b  = von ? b[7:4] : 4'h0;
    e.ft = (mh == 10'd799) && (mv == 10'd524);
    if (e.ft) mfc = mfc + 16'd1;
    e.fc = mfc;
    sb.push_back(e);
    @(posedge CLK25M);
    @(negedge CLK25M);
    got = sb.pop_front();
    check("hsync", 32'(HSYNC), 32'(got.hs));
    check("vsync", 32'(VSYNC), 32'(got.vs));
    check("vga_red", 32'(vgaRed), 32'(got.r));
    check("vga_green", 32'(vgaGreen), 32'(got.g));
    check("vga_blue", 32'(vgaBlue), 32'(got.b));
`ifdef VGA_FRAME_TICK_EN
    check("frame_tick", 32'(FrameTick), 32'(got.ft));
    check("frame_count", 32'(FrameCount), 32'(got.fc));
    if (FrameTick) ft_seen++;
`endif
    if (mh == 10'd799) begin
      mh = 10'd0;
      mv = (mv == 10'd524) ? 10'd0 : mv + 10'd1;
    end else begin
      mh = mh + 10'd1;
    end
  endtask

  // Jump the counters to a chosen position between clock edges.
  task automatic preload(input logic [9:0] h, input logic [9:0] v);
    force dut.h_cnt = h;
    force dut.v_cnt = v;
    #1;
    release dut.h_cnt;
    release dut.v_cnt;
    mh = h;
    mv = v;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hcount"}, 32'(Hcount), 32'd0);
    check({tag, "_vcount"}, 32'(Vcount), 32'd0);
    check({tag, "_videoon"}, 32'(VideoOn), 32'd1);
    check({tag, "_hsync"}, 32'(HSYNC), 32'd1);
    check({tag, "_vsync"}, 32'(VSYNC), 32'd1);
    check({tag, "_rgb"}, 32'({vgaRed, vgaGreen, vgaBlue}), 32'd0);
  endtask

  initial begin
    int hs_low;
    int vs_low;
    int first_h;
    int first_v;
    Reset = 1'b1;
    Red = 8'h00;
    Green = 8'h00;
    Blue = 8'h00;
    mh = 10'd0;
    mv = 10'd0;
    mfc = 16'd0;
    ft_seen = 0;

    // Power-on reset.
    repeat (3) @(negedge CLK25M);
    check_reset_state("por");
    Reset = 1'b0;
    repeat (5) tick(8'hFF, 8'hFF, 8'hFF);

    // Reset asserted mid-line at h=300, v=100, held three cycles.
    preload(10'd295, 10'd100);
    repeat (5) tick(8'hA5, 8'h5A, 8'h3C);
    check("pre_reset_h", 32'(Hcount), 32'd300);
    Reset = 1'b1;
    #1;
    check_reset_state("async");
    sb.delete();
    repeat (3) begin
      @(negedge CLK25M);
      check_reset_state("hold");
    end
    Reset = 1'b0;
    mh = 10'd0;
    mv = 10'd0;
    mfc = 16'd0;

    // One full line with the constant test colour.
    hs_low = 0;
    first_h = -1;
    repeat (801) begin
      tick(8'hC8, 8'h7D, 8'h32);
      if (!HSYNC) begin
        if (first_h < 0) first_h = int'(Hcount);
        hs_low++;
      end
      if (Hcount == 10'd640) begin
        check("rgb_last_vis_r", 32'(vgaRed), 32'hC);
        check("rgb_last_vis_g", 32'(vgaGreen), 32'h7);
        check("rgb_last_vis_b", 32'(vgaBlue), 32'h3);
      end
      if (Hcount == 10'd641) check("rgb_first_blank", 32'({vgaRed, vgaGreen, vgaBlue}), 32'd0);
    end
    check("hsync_low_cycles", 32'(hs_low), 32'd96);
    check("hsync_first_low_h", 32'(first_h), 32'd657);
    check("line_wrap_v", 32'(Vcount), 32'd1);

    // Random colours over the visible/blank boundary.
    preload(10'd630, 10'd200);
    repeat (20) tick(8'($urandom), 8'($urandom), 8'($urandom));

    // Vertical sync window: lines 490 and 491.
    preload(10'd798, 10'd489);
    vs_low = 0;
    first_h = -1;
    first_v = -1;
    repeat (1620) begin
      tick(8'($urandom), 8'($urandom), 8'($urandom));
      if (!VSYNC) begin
        if (first_h < 0) begin
          first_h = int'(Hcount);
          first_v = int'(Vcount);
        end
        vs_low++;
      end
    end
    check("vsync_low_cycles", 32'(vs_low), 32'd1600);
    check("vsync_first_low_h", 32'(first_h), 32'd1);
    check("vsync_first_low_v", 32'(first_v), 32'd490);

    // Aliasing of lines 512+ in the 9-bit Vcount.
    preload(10'd795, 10'd514);
    repeat (10) tick(8'hC8, 8'h7D, 8'h32);
    preload(10'd100, 10'd515);
    check("alias_vcount", 32'(Vcount), 32'd3);
    check("alias_videoon", 32'(VideoOn), 32'd0);
    repeat (3) tick(8'hC8, 8'h7D, 8'h32);
    check("alias_rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'd0);

    // End of frame: both counters wrap together.
    preload(10'd797, 10'd524);
    repeat (6) tick(8'hC8, 8'h7D, 8'h32);
    check("frame_wrap_v", 32'(Vcount), 32'd0);
    check("frame_wrap_h", 32'(Hcount), 32'd3);

`ifdef VGA_FRAME_TICK_EN
    repeat (2) begin
      preload(10'd790, 10'd524);
      repeat (20) tick(8'h11, 8'h22, 8'h33);
    end
    check("frame_tick_pulses", 32'(ft_seen), 32'd3);
    check("frame_count_3", 32'(FrameCount), 32'd3);
    force dut.frame_cnt = 16'hFFFE;
    #1;
    release dut.frame_cnt;
    mfc = 16'hFFFE;
    repeat (2) begin
      preload(10'd795, 10'd524);
      repeat (10) tick(8'h11, 8'h22, 8'h33);
    end
    check("frame_count_wrap", 32'(FrameCount), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Timing producer for the 640x480@60 Hz VGA display path. Generates the Hcount/Vcount pixel coordinates that the playfield colour logic consumes, and the HSYNC/VSYNC pins.
Takes the 8-bit-per-channel Red/Green/Blue returned by that logic and drives the Basys3 4-bit VGA DAC pins, blanked outside the visible area. Sync and colour pins are aligned by one output register stage.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
CLK25M  input  1  25 MHz pixel clock; the only clock
Reset  input  1  asynchronous, active-high reset
Red  input  8  pixel red from colour logic, combinational on Hcount/Vcount
Green  input  8  pixel green
Blue  input  8  pixel blue
Hcount  output  10  current horizontal counter, 0..H_TOTAL-1
Vcount  output  9  current vertical counter, low 9 bits
VideoOn  output  1  high when Hcount<H_VISIBLE and vertical counter<V_VISIBLE (combinational from counters)
vgaRed  output  4  registered DAC red
vgaGreen  output  4  registered DAC green
vgaBlue  output  4  registered DAC blue
HSYNC  output  1  registered, active-low
VSYNC  output  1  registered, active-low

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525).
- Reset is asynchronous and active-high: one clock, CLK25M; async active-high Reset.
- While Reset is high, each of the following holds its value:
  - h_cnt=0, v_cnt=0
  - HSYNC=1, VSYNC=1
  - vgaRed/vgaGreen/vgaBlue=0
- VideoOn is 1 during reset, because it is derived from the counters at 0,0.
- Reset released mid-frame restarts the frame at 0,0 with no partial-line output.
- h_cnt is 10 bits and increments every CLK25M.
  - At H_TOTAL-1 it wraps to 0 and v_cnt advances.
- v_cnt is 10 bits internally.
  - It increments only on the h_cnt wrap cycle.
  - At V_TOTAL-1 coincident with the h wrap, both wrap to 0 in the same cycle.
- Hcount = h_cnt.
- Vcount = v_cnt[8:0], truncated.
  - Lines 512..524 alias to 0..12. This is harmless because VideoOn=0 there.
  - Consumers gate on VideoOn.
- Sync windows are decoded from the current counters:
  - hsync_n = 0 for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vsync_n = 0 for v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491.
- Output stage, a single register at each CLK25M posedge:
  - HSYNC <= hsync_n and VSYNC <= vsync_n.
  - vgaRed <= VideoOn ? Red[7:4] : 0. Green and Blue use the same rule.
- Latency: pins reflect the counter value of the previous cycle, with sync and RGB mutually aligned.
  - Colour logic must be combinational from Hcount/Vcount within one 40 ns cycle.
- No handshake or back-pressure: free-running.
- Parameter changes must keep H_TOTAL<=1024 and V_TOTAL<=1024.

Optional Feature:
- Macro VGA_FRAME_TICK_EN.
- When defined, two extra outputs are added:
  - FrameTick (1 bit): a one-cycle registered pulse, high in the cycle after h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. It is therefore aligned with pins showing pixel 0,0.
  - FrameCount (16 bits): increments on each FrameTick and wraps 65535->0.
- Both outputs reset to 0.
- The game logic uses FrameTick as a clock-enable in place of derived clocks.
- When not defined, the ports and their logic are absent, and the remaining behaviour is identical.

Test Plan:
- Assert Reset mid-line at h=300, v=100, hold 3 cycles, release -> during reset: HSYNC=1, VSYNC=1, RGB=0, Hcount=0, Vcount=0. After release, Hcount counts 0,1,2...
- Free-run one line -> Hcount 0..799 then 0. Vcount increments exactly on the wrap edge. HSYNC pin is low for 96 cycles, first low when Hcount=657 (one-cycle lag).
- Free-run one frame -> 800*525=420000 cycles between Vcount=0 starts. VSYNC pin is low for 2 lines (1600 cycles), starting at the cycle after h=0, v=490.
- Drive Red=8'hC8, Green=8'h7D, Blue=8'h32 constant. At h=639 -> next cycle vgaRed=4'hC, vgaGreen=4'h7, vgaBlue=4'h3. At h=640 -> next cycle all 0. Lines 480..524 are all 0.
- Check aliasing at v_cnt=515 -> Vcount=3, VideoOn=0, RGB pins 0.
- With VGA_FRAME_TICK_EN: run 3 frames -> FrameTick is high exactly 3 single cycles, 420000 apart, and FrameCount=3. Preload FrameCount near 65535 by force -> wraps to 0.
